// File: rtl/eth_header_arbiter.sv
// Round-robin arbiter sharing one registered Ethernet header output among NUM_REQ sources.
// Define ETH_HDR_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module eth_header_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = ($clog2(NUM_REQ) > 0) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    sync_rst,
    input  logic [NUM_REQ-1:0]      in_valid,
    output logic [NUM_REQ-1:0]      in_ready,
    input  logic [NUM_REQ*48-1:0]   in_src_mac,
    input  logic [NUM_REQ*48-1:0]   in_dest_mac,
    input  logic [NUM_REQ*16-1:0]   in_eth_type,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [47:0]             out_src_mac,
    output logic [47:0]             out_dest_mac,
    output logic [15:0]             out_eth_type,
    output logic [IDX_W-1:0]        out_grant_idx
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic             found;
    logic             can_accept;
    logic             accept;

    assign can_accept = (state == ST_IDLE) || (out_ready && (state == ST_HOLD));
    assign accept     = can_accept && found && !sync_rst;
    assign out_valid  = (state == ST_HOLD);

    // Search starts at rr_ptr and wraps; fixed-priority builds pin rr_ptr to 0.
    always_comb begin
        int unsigned idx;
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && in_valid[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            in_ready[i] = accept && (winner == IDX_W'(i));
        end
    end

`ifdef ETH_HDR_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [IDX_W-1:0] rr_next;

    assign rr_next = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : IDX_W'(winner + 1'b1);

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= rr_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state         <= ST_IDLE;
            out_src_mac   <= '0;
            out_dest_mac  <= '0;
            out_eth_type  <= '0;
            out_grant_idx <= '0;
        end else if (accept) begin
            state         <= ST_HOLD;
            out_src_mac   <= in_src_mac[int'(winner)*48 +: 48];
            out_dest_mac  <= in_dest_mac[int'(winner)*48 +: 48];
            out_eth_type  <= in_eth_type[int'(winner)*16 +: 16];
            out_grant_idx <= winner;
        end else if ((state == ST_HOLD) && out_ready) begin
            state <= ST_IDLE;
        end
    end

endmodule

// File: tb/tb_eth_header_arbiter.sv
// Directed self-checking bench for eth_header_arbiter (NUM_REQ=2 and NUM_REQ=3 instances).
module tb_eth_header_arbiter;

`ifdef ETH_HDR_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // NUM_REQ=2 instance
    logic        rst2;
    logic [1:0]  in_valid2, in_ready2;
    logic [95:0] in_src2, in_dest2;
    logic [31:0] in_type2;
    logic        out_valid2, out_ready2;
    logic [47:0] out_src2, out_dest2;
    logic [15:0] out_type2;
    logic [0:0]  out_idx2;

    // NUM_REQ=3 instance
    logic         rst3;
    logic [2:0]   in_valid3, in_ready3;
    logic [143:0] in_src3, in_dest3;
    logic [47:0]  in_type3;
    logic         out_valid3, out_ready3;
    logic [47:0]  out_src3, out_dest3;
    logic [15:0]  out_type3;
    logic [1:0]   out_idx3;

    eth_header_arbiter #(.NUM_REQ(2)) dut2 (
        .clk(clk), .sync_rst(rst2),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_src_mac(in_src2), .in_dest_mac(in_dest2), .in_eth_type(in_type2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_src_mac(out_src2), .out_dest_mac(out_dest2), .out_eth_type(out_type2),
        .out_grant_idx(out_idx2)
    );

    eth_header_arbiter #(.NUM_REQ(3)) dut3 (
        .clk(clk), .sync_rst(rst3),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .in_src_mac(in_src3), .in_dest_mac(in_dest3), .in_eth_type(in_type3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_src_mac(out_src3), .out_dest_mac(out_dest3), .out_eth_type(out_type3),
        .out_grant_idx(out_idx3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [0:0] exp_idx;

        rst2 = 1'b1; rst3 = 1'b1;
        out_ready2 = 1'b0; out_ready3 = 1'b0;
        in_valid2 = 2'b11; in_valid3 = 3'b000;
        in_src2  = {48'h0200_0000_0002, 48'h0200_0000_0001};
        in_dest2 = {48'hFFFF_FFFF_FFFF, 48'h0A0B_0C0D_0E0F};
        in_type2 = {16'h0806, 16'h0800};
        in_src3  = {48'h0300_0000_0003, 48'h0300_0000_0002, 48'h0300_0000_0001};
        in_dest3 = {48'h0D00_0000_0003, 48'h0D00_0000_0002, 48'h0D00_0000_0001};
        in_type3 = {16'h86DD, 16'h0806, 16'h0800};

        // Reset state, in_ready gated while reset is asserted
        #1;
        check("rst_in_ready", 64'(in_ready2), 64'h0);
        step();
        check("rst_out_valid", 64'(out_valid2), 64'h0);
        check("rst_eth_type", 64'(out_type2), 64'h0);
        check("rst_src_mac", 64'(out_src2), 64'h0);
        check("rst_grant_idx", 64'(out_idx2), 64'h0);
        check("rst_in_ready_held", 64'(in_ready2), 64'h0);

        // Single requester
        rst2 = 1'b0; rst3 = 1'b0;
        in_valid2 = 2'b01; out_ready2 = 1'b1;
        #1;
        check("single_in_ready", 64'(in_ready2), 64'h1);
        step();
        check("single_out_valid", 64'(out_valid2), 64'h1);
        check("single_eth_type", 64'(out_type2), 64'h0800);
        check("single_src_mac", 64'(out_src2), 64'h0200_0000_0001);
        check("single_dest_mac", 64'(out_dest2), 64'h0A0B_0C0D_0E0F);
        check("single_grant_idx", 64'(out_idx2), 64'h0);

        // Contention from a fresh pointer
        rst2 = 1'b1; in_valid2 = 2'b00;
        step();
        rst2 = 1'b0; in_valid2 = 2'b11; out_ready2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_idx = FIXED ? 1'b0 : 1'(i % 2);
            #1;
            check("rr_in_ready", 64'(in_ready2), 64'(2'b01 << exp_idx));
            step();
            check("rr_grant_idx", 64'(out_idx2), 64'(exp_idx));
            check("rr_out_valid", 64'(out_valid2), 64'h1);
            check("rr_eth_type", 64'(out_type2), exp_idx ? 64'h0806 : 64'h0800);
        end

        // Backpressure: everything holds for 10 cycles
        exp_idx = FIXED ? 1'b0 : 1'b1;
        out_ready2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("bp_in_ready", 64'(in_ready2), 64'h0);
            step();
            check("bp_out_valid", 64'(out_valid2), 64'h1);
            check("bp_grant_idx", 64'(out_idx2), 64'(exp_idx));
            check("bp_eth_type", 64'(out_type2), exp_idx ? 64'h0806 : 64'h0800);
        end
        out_ready2 = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(in_ready2), 64'h1);
        step();
        check("bp_release_grant", 64'(out_idx2), 64'h0);
        check("bp_release_valid", 64'(out_valid2), 64'h1);

        // Drain with no requesters: output empties, fields retained
        in_valid2 = 2'b00;
        #1;
        check("idle_in_ready", 64'(in_ready2), 64'h0);
        step();
        check("drain_out_valid", 64'(out_valid2), 64'h0);
        check("drain_eth_type_kept", 64'(out_type2), 64'h0800);

        // Reset mid-HOLD
        in_valid2 = 2'b10;
        step();
        check("pre_rst_grant", 64'(out_idx2), 64'h1);
        out_ready2 = 1'b0; in_valid2 = 2'b11; rst2 = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready2), 64'h0);
        step();
        check("midrst_out_valid", 64'(out_valid2), 64'h0);
        check("midrst_grant_idx", 64'(out_idx2), 64'h0);
        rst2 = 1'b0; out_ready2 = 1'b1;
        #1;
        check("post_rst_rr_ptr", 64'(in_ready2), 64'h1);

        // Wrap on NUM_REQ=3
        in_valid3 = 3'b100; out_ready3 = 1'b1;
        #1;
        check("wrap_in_ready2", 64'(in_ready3), 64'h4);
        step();
        check("wrap_grant2", 64'(out_idx3), 64'h2);
        check("wrap_type2", 64'(out_type3), 64'h86DD);
        in_valid3 = 3'b101;
        #1;
        check("wrap_in_ready0", 64'(in_ready3), 64'h1);
        step();
        check("wrap_grant0", 64'(out_idx3), 64'h0);
        check("wrap_src0", 64'(out_src3), 64'h0300_0000_0001);
        in_valid3 = 3'b110;
        step();
        check("n3_grant1", 64'(out_idx3), 64'h1);
        in_valid3 = 3'b101;
        step();
        check("n3_after1", 64'(out_idx3), FIXED ? 64'h0 : 64'h2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
